// File: rtl/csr_file_trap_pkg.sv
// Shared constants, types and helpers for the machine-mode CSR file.
// CSR_VECTORED_MTVEC_EN enables vectored mtvec mode (MODE = 01).
package csr_file_trap_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [31:0] MSTATUS_WMASK   = 32'h0000_0088;
    localparam logic [31:0] MSTATUS_MPP_RO  = 32'h0000_1800;
    localparam logic [31:0] MIE_WMASK       = 32'h0000_0888;
    localparam logic [31:0] MEPC_WMASK      = 32'hFFFF_FFFC;
    localparam logic [31:0] MTVEC_BASE_MASK = 32'hFFFF_FFFC;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    localparam int IRQ_MSI = 3;
    localparam int IRQ_MTI = 7;
    localparam int IRQ_MEI = 11;
    localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;

    typedef enum logic [1:0] {
        OP_RW0 = 2'b00,
        OP_RW  = 2'b01,
        OP_RS  = 2'b10,
        OP_RC  = 2'b11
    } csr_op_e;

    typedef struct packed {
        logic [31:0] mstatus;
        logic [31:0] mie;
        logic [31:0] mtvec;
        logic [31:0] mscratch;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic [31:0] mtval;
        logic [31:0] mip;
        logic [63:0] mcycle;
        logic [63:0] minstret;
        logic [31:0] hartid;
        logic [31:0] misa;
    } csr_view_t;

    function automatic logic [31:0] csr_apply_op(input logic [1:0] op, input logic [31:0] old_v,
                                                 input logic [31:0] wdata);
        logic [31:0] r;
        case (op)
            OP_RS:   r = old_v | wdata;
            OP_RC:   r = old_v & ~wdata;
            default: r = wdata;
        endcase
        return r;
    endfunction

    // Returns {implemented, data}; unimplemented addresses yield {0, 0}.
    function automatic logic [32:0] csr_read(input logic [11:0] addr, input csr_view_t v);
        logic [32:0] r;
        r = {1'b1, 32'h0000_0000};
        case (addr)
            CSR_MSTATUS:   r[31:0] = v.mstatus;
            CSR_MISA:      r[31:0] = v.misa;
            CSR_MIE:       r[31:0] = v.mie;
            CSR_MTVEC:     r[31:0] = v.mtvec;
            CSR_MSCRATCH:  r[31:0] = v.mscratch;
            CSR_MEPC:      r[31:0] = v.mepc;
            CSR_MCAUSE:    r[31:0] = v.mcause;
            CSR_MTVAL:     r[31:0] = v.mtval;
            CSR_MIP:       r[31:0] = v.mip;
            CSR_MCYCLE:    r[31:0] = v.mcycle[31:0];
            CSR_MINSTRET:  r[31:0] = v.minstret[31:0];
            CSR_MCYCLEH:   r[31:0] = v.mcycle[63:32];
            CSR_MINSTRETH: r[31:0] = v.minstret[63:32];
            CSR_MHARTID:   r[31:0] = v.hartid;
            default:       r = {1'b0, 32'h0000_0000};
        endcase
        return r;
    endfunction

    function automatic logic [31:0] mtvec_legalize(input logic [31:0] v);
`ifdef CSR_VECTORED_MTVEC_EN
        return (v[1:0] == 2'b01) ? v : (v & MTVEC_BASE_MASK);
`else
        return v & MTVEC_BASE_MASK;
`endif
    endfunction

endpackage

// File: rtl/csr_file_trap_counter.sv
// CNT_WIDTH-bit counter with increment enable and 32-bit low/high write ports.
// Bits above CNT_WIDTH read as zero; a write suppresses the increment.
module csr_counter #(
    parameter int CNT_WIDTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc,
    input  logic        i_we_lo,
    input  logic        i_we_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_value
);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 w_unused_wdata;

    assign w_unused_wdata = &{1'b0, i_wdata};
    assign o_value        = 64'(r_cnt);

    // Counter register: writes to either half take priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_we_lo) begin
            r_cnt[31:0] <= i_wdata;
        end else if (i_we_hi) begin
            r_cnt[CNT_WIDTH-1:32] <= i_wdata[CNT_WIDTH-33:0];
        end else if (i_inc) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/csr_file_trap.sv
// Machine-mode CSR file with trap entry, mret, counters and synchronised interrupts.
// Define CSR_VECTORED_MTVEC_EN for vectored mtvec; default build is direct mode only.
module csr_file_trap
    import csr_file_trap_pkg::*;
#(
    parameter int          HART_ID     = 0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int          CNT_WIDTH   = 64,
    parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [1:0]  op_i,
    input  logic [11:0] waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [11:0] raddr_i,
    output logic [31:0] rdata_o,
    output logic        illegal_o,
    input  logic        trap_i,
    input  logic [31:0] trap_cause_i,
    input  logic [31:0] trap_pc_i,
    input  logic [31:0] trap_val_i,
    input  logic        mret_i,
    input  logic        instret_i,
    input  logic        irq_soft_i,
    input  logic        irq_timer_i,
    input  logic        irq_ext_i,
    output logic        irq_req_o,
    output logic [31:0] irq_cause_o,
    output logic [31:0] trap_vector_o,
    output logic [31:0] mepc_o
);

    logic        r_mie_b, r_mpie;
    logic [31:0] r_mie_csr, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
    logic [31:0] r_rdata;
    logic        r_illegal;
    logic [2:0]  r_irq_meta, r_irq_sync;   // {ext, timer, soft}

    csr_view_t   w_view;
    logic [63:0] w_mcycle, w_minstret;
    logic [31:0] w_mip, w_pend, w_old, w_new, w_tvec, w_irq_cause;
    logic [32:0] w_rd, w_wr_rd;
    logic        w_wen;

    assign w_mip = {20'h0_0000, r_irq_sync[2], 3'b000, r_irq_sync[1], 3'b000, r_irq_sync[0], 3'b000};

    // Architectural view of every CSR, shared by the read port and the RS/RC old value.
    always_comb begin
        w_view          = '0;
        w_view.mstatus  = MSTATUS_MPP_RO | {24'h00_0000, r_mpie, 3'b000, r_mie_b, 3'b000};
        w_view.mie      = r_mie_csr;
        w_view.mtvec    = r_mtvec;
        w_view.mscratch = r_mscratch;
        w_view.mepc     = r_mepc;
        w_view.mcause   = r_mcause;
        w_view.mtval    = r_mtval;
        w_view.mip      = w_mip;
        w_view.mcycle   = w_mcycle;
        w_view.minstret = w_minstret;
        w_view.hartid   = 32'(HART_ID);
        w_view.misa     = MISA_VAL;
    end

    assign w_rd    = csr_read(raddr_i, w_view);
    assign w_wr_rd = csr_read(waddr_i, w_view);
    assign w_old   = w_wr_rd[31:0];
    assign w_new   = csr_apply_op(op_i, w_old, wdata_i);
    assign w_wen   = we_i & w_wr_rd[32];

    csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (1'b1),
        .i_we_lo (w_wen && (waddr_i == CSR_MCYCLE)),
        .i_we_hi (w_wen && (waddr_i == CSR_MCYCLEH)),
        .i_wdata (w_new),
        .o_value (w_mcycle)
    );

    csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_minstret (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (instret_i),
        .i_we_lo (w_wen && (waddr_i == CSR_MINSTRET)),
        .i_we_hi (w_wen && (waddr_i == CSR_MINSTRETH)),
        .i_wdata (w_new),
        .o_value (w_minstret)
    );

    // Registered read port and interrupt synchronisers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata    <= 32'h0000_0000;
            r_illegal  <= 1'b0;
            r_irq_meta <= 3'b000;
            r_irq_sync <= 3'b000;
        end else begin
            r_rdata    <= w_rd[31:0];
            r_illegal  <= ~w_rd[32];
            r_irq_meta <= {irq_ext_i, irq_timer_i, irq_soft_i};
            r_irq_sync <= r_irq_meta;
        end
    end

    // mstatus: trap beats mret, which beats a software write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mie_b <= 1'b0;
            r_mpie  <= 1'b0;
        end else if (trap_i) begin
            r_mpie  <= r_mie_b;
            r_mie_b <= 1'b0;
        end else if (mret_i) begin
            r_mie_b <= r_mpie;
            r_mpie  <= 1'b1;
        end else if (w_wen && (waddr_i == CSR_MSTATUS)) begin
            r_mie_b <= w_new[MSTATUS_MIE_BIT];
            r_mpie  <= w_new[MSTATUS_MPIE_BIT];
        end
    end

    // Plain CSRs; the trap assignments come last so they override a same-cycle write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mie_csr  <= 32'h0000_0000;
            r_mtvec    <= mtvec_legalize(MTVEC_RESET);
            r_mscratch <= 32'h0000_0000;
            r_mepc     <= 32'h0000_0000;
            r_mcause   <= 32'h0000_0000;
            r_mtval    <= 32'h0000_0000;
        end else begin
            if (w_wen) begin
                case (waddr_i)
                    CSR_MIE:      r_mie_csr  <= w_new & MIE_WMASK;
                    CSR_MTVEC:    r_mtvec    <= mtvec_legalize(w_new);
                    CSR_MSCRATCH: r_mscratch <= w_new;
                    CSR_MEPC:     r_mepc     <= w_new & MEPC_WMASK;
                    CSR_MCAUSE:   r_mcause   <= w_new;
                    CSR_MTVAL:    r_mtval    <= w_new;
                    default:      ;
                endcase
            end
            if (trap_i) begin
                r_mepc   <= trap_pc_i & MEPC_WMASK;
                r_mcause <= trap_cause_i;
                r_mtval  <= trap_val_i;
            end
        end
    end

    // Highest-priority pending-and-enabled interrupt: external > software > timer.
    always_comb begin
        w_pend = w_mip & r_mie_csr;
        if (w_pend[IRQ_MEI]) begin
            w_irq_cause = CAUSE_MEI;
        end else if (w_pend[IRQ_MSI]) begin
            w_irq_cause = CAUSE_MSI;
        end else if (w_pend[IRQ_MTI]) begin
            w_irq_cause = CAUSE_MTI;
        end else begin
            w_irq_cause = 32'h0000_0000;
        end
    end

    // Trap target from mtvec base, offset by the registered cause in vectored mode.
    always_comb begin
        w_tvec = r_mtvec & MTVEC_BASE_MASK;
`ifdef CSR_VECTORED_MTVEC_EN
        if ((r_mtvec[1:0] == 2'b01) && r_mcause[31]) begin
            w_tvec = (r_mtvec & MTVEC_BASE_MASK) + {25'h000_0000, r_mcause[4:0], 2'b00};
        end else begin
            w_tvec = r_mtvec & MTVEC_BASE_MASK;
        end
`endif
    end

    assign rdata_o       = r_rdata;
    assign illegal_o     = r_illegal;
    assign irq_req_o     = r_mie_b & (|w_pend);
    assign irq_cause_o   = w_irq_cause;
    assign trap_vector_o = w_tvec;
    assign mepc_o        = r_mepc;

endmodule

// File: tb/tb_csr_file_trap.sv
// Scoreboard bench for csr_file_trap: a behavioural CSR model predicts each cycle's outputs.
// Honours CSR_VECTORED_MTVEC_EN in the same way as the design.
module tb_csr_file_trap;

    localparam int          CW    = 40;
    localparam logic [63:0] CMASK = 64'h0000_00FF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we_i = 1'b0, trap_i = 1'b0, mret_i = 1'b0, instret_i = 1'b0;
    logic        irq_soft_i = 1'b0, irq_timer_i = 1'b0, irq_ext_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [11:0] waddr_i = 12'h000, raddr_i = 12'h000;
    logic [31:0] wdata_i = 32'h0, trap_cause_i = 32'h0, trap_pc_i = 32'h0, trap_val_i = 32'h0;
    logic [31:0] rdata_o, irq_cause_o, trap_vector_o, mepc_o;
    logic        illegal_o, irq_req_o;

    csr_file_trap #(.HART_ID(3), .MTVEC_RESET(32'h0000_0100), .CNT_WIDTH(CW),
                    .MISA_VAL(32'h4000_0100)) dut (
        .clk(clk), .rst(rst), .we_i(we_i), .op_i(op_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .raddr_i(raddr_i), .rdata_o(rdata_o), .illegal_o(illegal_o), .trap_i(trap_i),
        .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i), .trap_val_i(trap_val_i),
        .mret_i(mret_i), .instret_i(instret_i), .irq_soft_i(irq_soft_i),
        .irq_timer_i(irq_timer_i), .irq_ext_i(irq_ext_i), .irq_req_o(irq_req_o),
        .irq_cause_o(irq_cause_o), .trap_vector_o(trap_vector_o), .mepc_o(mepc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        illegal;
        logic        irq;
        logic [31:0] cause;
        logic [31:0] tvec;
        logic [31:0] mepc;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    bit          m_mie_b = 0, m_mpie = 0;
    logic [31:0] m_mie_csr = 0, m_mtvec = 32'h100, m_mscratch = 0, m_mepc = 0, m_mcause = 0, m_mtval = 0;
    logic [63:0] m_cyc = 0, m_ins = 0;
    bit   [2:0]  m_s1 = 0, m_s2 = 0;   // {ext, timer, soft}, first and second sync stage

    function automatic logic [31:0] legal_mtvec(input logic [31:0] v);
`ifdef CSR_VECTORED_MTVEC_EN
        return ((v & 32'h3) == 32'h1) ? v : (v & ~32'h3);
`else
        return v & ~32'h3;
`endif
    endfunction

    function automatic logic [31:0] mip_val();
        return (m_s2[0] ? 32'h8 : 32'h0) | (m_s2[1] ? 32'h80 : 32'h0) | (m_s2[2] ? 32'h800 : 32'h0);
    endfunction

    function automatic logic [31:0] exp_read(input logic [11:0] a, output bit ok);
        logic [31:0] v;
        ok = 1;
        case (a)
            12'h300: v = 32'h1800 | (m_mie_b ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
            12'h301: v = 32'h4000_0100;
            12'h304: v = m_mie_csr;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'h344: v = mip_val();
            12'hB00: v = m_cyc[31:0];
            12'hB02: v = m_ins[31:0];
            12'hB80: v = m_cyc[63:32];
            12'hB82: v = m_ins[63:32];
            12'hF14: v = 32'd3;
            default: begin v = 32'h0; ok = 0; end
        endcase
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        exp_t        e;
        bit          ok, wok, cw, iw, n_mie_b, n_mpie;
        logic [31:0] old_v, nv, pend, tv;
        if (rst) begin
            m_mie_b = 0; m_mpie = 0; m_mie_csr = 0; m_mtvec = 32'h100; m_mscratch = 0;
            m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cyc = 0; m_ins = 0; m_s1 = 0; m_s2 = 0;
            sb.delete();
        end else begin
            e.rdata   = exp_read(raddr_i, ok);
            e.illegal = !ok;
            old_v = exp_read(waddr_i, wok);
            case (op_i)
                2'b10:   nv = old_v | wdata_i;
                2'b11:   nv = old_v & ~wdata_i;
                default: nv = wdata_i;
            endcase
            n_mie_b = m_mie_b; n_mpie = m_mpie; cw = 0; iw = 0;
            if (we_i && wok) begin
                case (waddr_i)
                    12'h300: begin n_mie_b = nv[3]; n_mpie = nv[7]; end
                    12'h304: m_mie_csr = nv & 32'h888;
                    12'h305: m_mtvec = legal_mtvec(nv);
                    12'h340: m_mscratch = nv;
                    12'h341: m_mepc = nv & ~32'h3;
                    12'h342: m_mcause = nv;
                    12'h343: m_mtval = nv;
                    12'hB00: begin m_cyc = {m_cyc[63:32], nv}; cw = 1; end
                    12'hB80: begin m_cyc = (({32'h0, nv} << 32) | (m_cyc & 64'hFFFF_FFFF)) & CMASK; cw = 1; end
                    12'hB02: begin m_ins = {m_ins[63:32], nv}; iw = 1; end
                    12'hB82: begin m_ins = (({32'h0, nv} << 32) | (m_ins & 64'hFFFF_FFFF)) & CMASK; iw = 1; end
                    default: ;
                endcase
            end
            if (!cw) m_cyc = (m_cyc + 64'd1) & CMASK;
            if (!iw && instret_i) m_ins = (m_ins + 64'd1) & CMASK;
            if (trap_i) begin
                m_mepc = trap_pc_i & ~32'h3; m_mcause = trap_cause_i; m_mtval = trap_val_i;
                n_mpie = m_mie_b; n_mie_b = 0;
            end else if (mret_i) begin
                n_mie_b = m_mpie; n_mpie = 1;
            end
            m_mie_b = n_mie_b; m_mpie = n_mpie;
            m_s2 = m_s1;
            m_s1 = {irq_ext_i, irq_timer_i, irq_soft_i};
            pend = mip_val() & m_mie_csr;
            e.irq = m_mie_b && (pend != 0);
            if (pend & 32'h800)     e.cause = 32'h8000_000B;
            else if (pend & 32'h8)  e.cause = 32'h8000_0003;
            else if (pend & 32'h80) e.cause = 32'h8000_0007;
            else                    e.cause = 32'h0;
            tv = m_mtvec & ~32'h3;
`ifdef CSR_VECTORED_MTVEC_EN
            if (((m_mtvec & 32'h3) == 32'h1) && m_mcause[31]) tv = tv + 4 * (m_mcause & 32'h1F);
`endif
            e.tvec = tv;
            e.mepc = m_mepc;
            sb.push_back(e);
        end
    end

    // Monitor: outputs are valid every cycle out of reset; compare against queued predictions.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("rdata", rdata_o, e.rdata);
                    chk("illegal", {31'd0, illegal_o}, {31'd0, e.illegal});
                    chk("irq_req", {31'd0, irq_req_o}, {31'd0, e.irq});
                    chk("irq_cause", irq_cause_o, e.cause);
                    chk("trap_vector", trap_vector_o, e.tvec);
                    chk("mepc", mepc_o, e.mepc);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; op_i = op; wdata_i = d;
        tick();
        we_i = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a);
        raddr_i = a;
        tick();
    endtask

    task automatic trap(input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] val,
                        input logic with_mret);
        trap_i = 1'b1; mret_i = with_mret; trap_cause_i = cause; trap_pc_i = pc; trap_val_i = val;
        tick();
        trap_i = 1'b0; mret_i = 1'b0;
    endtask

    localparam logic [11:0] ADDRS [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
        12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF14, 12'h7C0, 12'h123};

    initial begin
        tick(2);
        chk("reset_rdata", rdata_o, 32'h0);
        chk("reset_illegal", {31'd0, illegal_o}, 32'h0);
        chk("reset_mepc", mepc_o, 32'h0);
        chk("reset_irq_req", {31'd0, irq_req_o}, 32'h0);
        chk("reset_tvec", trap_vector_o, 32'h0000_0100);
        rst = 1'b0;

        rd(12'h301); rd(12'hF14); rd(12'h7C0);
        wr(12'h340, 2'b01, 32'hF0F0_0000); wr(12'h340, 2'b10, 32'h0000_000F);
        wr(12'h340, 2'b11, 32'hF000_0000); rd(12'h340);
        wr(12'h301, 2'b01, 32'hFFFF_FFFF); wr(12'h344, 2'b01, 32'hFFFF_FFFF); rd(12'h301); rd(12'h344);

        wr(12'h305, 2'b01, 32'h8000_0100); wr(12'h300, 2'b10, 32'h0000_0008);
        trap(32'd2, 32'h0000_1003, 32'h0000_DEAD, 1'b0);
        rd(12'h342); rd(12'h343); rd(12'h300);
        mret_i = 1'b1; tick(); mret_i = 1'b0;
        rd(12'h300);

        wr(12'h304, 2'b01, 32'h0000_0888); wr(12'h300, 2'b10, 32'h0000_0008);
        irq_timer_i = 1'b1; irq_ext_i = 1'b1; tick(3);
        irq_ext_i = 1'b0; tick(3);
        irq_soft_i = 1'b1; rd(12'h344); tick(2);
        irq_soft_i = 1'b0; irq_timer_i = 1'b0; tick(3);

        wr(12'hB00, 2'b01, 32'hFFFF_FFFF); wr(12'hB80, 2'b01, 32'h0);
        rd(12'hB80); rd(12'hB80); rd(12'hB00);
        wr(12'hB80, 2'b01, 32'hFFFF_FFFF); wr(12'hB00, 2'b01, 32'hFFFF_FFFE);
        rd(12'hB00); rd(12'hB80); rd(12'hB00); rd(12'hB80);
        wr(12'hB82, 2'b01, 32'h0000_0007); instret_i = 1'b1; wr(12'hB02, 2'b01, 32'hFFFF_FFFF);
        rd(12'hB02); rd(12'hB82); instret_i = 1'b0; rd(12'hB02);
        wr(12'h300, 2'b10, 32'h0000_0008);
        trap(32'd5, 32'h0000_2222, 32'h0000_0011, 1'b1);
        rd(12'h300);
        we_i = 1'b1; waddr_i = 12'h341; op_i = 2'b01; wdata_i = 32'h1234_5678;
        trap(32'd7, 32'h0000_3337, 32'h0000_0022, 1'b0);
        rd(12'h341);

        wr(12'h305, 2'b01, 32'h8000_0001); rd(12'h305);
        trap(32'h8000_0007, 32'h0000_4000, 32'h0, 1'b0); rd(12'h305);
        wr(12'h305, 2'b01, 32'h8000_0003); rd(12'h305);

        rd(12'h301);
        @(posedge clk); #3; rst = 1'b1; #1;
        chk("async_rdata", rdata_o, 32'h0);
        chk("async_mepc", mepc_o, 32'h0);
        chk("async_tvec", trap_vector_o, 32'h0000_0100);
        chk("async_irq_req", {31'd0, irq_req_o}, 32'h0);
        tick(); rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            we_i        = ($urandom_range(0, 1) == 1);
            op_i        = 2'($urandom_range(0, 3));
            waddr_i     = ADDRS[$urandom_range(0, 15)];
            raddr_i     = ADDRS[$urandom_range(0, 15)];
            wdata_i     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            trap_i      = ($urandom_range(0, 15) == 0);
            mret_i      = ($urandom_range(0, 15) == 0);
            trap_cause_i = ($urandom_range(0, 1) == 1) ? (32'h8000_0000 | 32'($urandom_range(0, 31))) : $urandom;
            trap_pc_i   = $urandom;
            trap_val_i  = $urandom;
            instret_i   = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0) irq_soft_i  = ~irq_soft_i;
            if ($urandom_range(0, 7) == 0) irq_timer_i = ~irq_timer_i;
            if ($urandom_range(0, 7) == 0) irq_ext_i   = ~irq_ext_i;
            tick();
        end
        we_i = 1'b0; trap_i = 1'b0; mret_i = 1'b0; instret_i = 1'b0;
        tick(3);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
